// File: rtl/ikbd_link_pkg.sv
// Shared types and constants for the IKBD host serial link.
package ikbd_link_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} link_state_t;

  localparam logic LINK_IDLE_LVL = 1'b1;
  localparam int   DATA_BITS     = 8;

endpackage

// File: rtl/ikbd_link_fifo.sv
// Small synchronous FIFO with registered pointers and occupancy count.
module ikbd_link_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop on a full FIFO frees the slot in the same cycle, so the push still lands.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ikbd_serial_link.sv
// Host-side 8N1 serial link to the HD63701 IKBD SCI: TX queue + serialiser, RX deserialiser + queue.
module ikbd_serial_link
  import ikbd_link_pkg::*;
#(
  parameter int BIT_CYCLES = 256,
  parameter int SAMPLE_PT  = 128,
  parameter int FIFO_AW    = 2
) (
  input  logic       CLKx2,
  input  logic       RST_N,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       ser_txd,
  input  logic       ser_rxd,
  input  logic       err_clr,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       tx_busy
);

  localparam int             CW       = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_SMP  = CW'(SAMPLE_PT);
  localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

  logic                 tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_BITS-1:0] tx_head;
  link_state_t          tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 txd_q, txd_d;
  logic                 tx_bit_end;

  logic                 rx_push, rx_pop, rx_full, rx_empty;
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  link_state_t          rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 rx_wait_q, rx_wait_d;
  logic                 rx_bit_end, rx_smp;
  logic                 ovr_set, ferr_set, ovr_q, ferr_q;

  assign tx_ready = ~tx_full;
  assign tx_push  = tx_valid & ~tx_full;
  assign tx_busy  = (tx_state_q != IDLE) | ~tx_empty;
  assign ser_txd  = txd_q;

  ikbd_link_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_tx_fifo (
    .clk_i(CLKx2), .rst_ni(RST_N), .push_i(tx_push), .wdata_i(tx_data),
    .pop_i(tx_pop), .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
  );

  assign tx_bit_end = (tx_cnt_q == CNT_LAST);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_pop     = 1'b0;
    if (tx_state_q != IDLE) tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    case (tx_state_q)
      IDLE: if (!tx_empty) begin
        tx_pop     = 1'b1;
        tx_sh_d    = tx_head;
        tx_cnt_d   = '0;
        tx_state_d = START;
      end
      START: if (tx_bit_end) begin
        tx_state_d = DATA;
        tx_bit_d   = '0;
      end
      DATA: if (tx_bit_end) begin
        tx_sh_d  = tx_sh_q >> 1;
        tx_bit_d = tx_bit_q + 1'b1;
        if (tx_bit_q == BIT_LAST) tx_state_d = STOP;
      end
      STOP: if (tx_bit_end) begin
        // Chain straight into the next start bit so queued frames leave with no idle gap.
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_head;
          tx_state_d = START;
        end else begin
          tx_state_d = IDLE;
        end
      end
      default: tx_state_d = IDLE;
    endcase
    case (tx_state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = tx_sh_q[0];
      default: txd_d = LINK_IDLE_LVL;
    endcase
  end

  always_ff @(posedge CLKx2 or negedge RST_N) begin
    if (!RST_N) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= LINK_IDLE_LVL;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
    end
  end

  assign rx_valid = ~rx_empty;
  assign rx_pop   = rx_ready & ~rx_empty;
  assign ovr_set  = rx_push & rx_full & ~rx_pop;

  ikbd_link_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_rx_fifo (
    .clk_i(CLKx2), .rst_ni(RST_N), .push_i(rx_push), .wdata_i(rx_sh_q),
    .pop_i(rx_pop), .rdata_o(rx_data), .full_o(rx_full), .empty_o(rx_empty)
  );

  assign rx_bit_end = (rx_cnt_q == CNT_LAST);
  assign rx_smp     = (rx_cnt_q == CNT_SMP);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_wait_d  = rx_wait_q;
    rx_push    = 1'b0;
    ferr_set   = 1'b0;
    if (rx_state_q != IDLE && !rx_wait_q) rx_cnt_d = rx_bit_end ? '0 : rx_cnt_q + 1'b1;
    case (rx_state_q)
      IDLE: if (rx_prev_q && !rx_sync_q) begin
        rx_cnt_d   = '0;
        rx_state_d = START;
      end
      START: begin
        if (rx_smp && rx_sync_q) begin
          rx_state_d = IDLE;
        end else if (rx_bit_end) begin
          rx_state_d = DATA;
          rx_bit_d   = '0;
        end
      end
      DATA: begin
        if (rx_smp) rx_sh_d = {rx_sync_q, rx_sh_q[DATA_BITS-1:1]};
        if (rx_bit_end) begin
          rx_bit_d = rx_bit_q + 1'b1;
          if (rx_bit_q == BIT_LAST) rx_state_d = STOP;
        end
      end
      STOP: begin
        // A bad stop bit parks here until the line is seen high again.
        if (rx_wait_q) begin
          if (rx_sync_q) begin
            rx_wait_d  = 1'b0;
            rx_state_d = IDLE;
          end
        end else if (rx_smp) begin
          if (rx_sync_q) begin
            rx_push    = 1'b1;
            rx_state_d = IDLE;
          end else begin
            ferr_set  = 1'b1;
            rx_wait_d = 1'b1;
          end
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLKx2 or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta_q  <= LINK_IDLE_LVL;
      rx_sync_q  <= LINK_IDLE_LVL;
      rx_prev_q  <= LINK_IDLE_LVL;
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_wait_q  <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_meta_q  <= ser_rxd;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_wait_q  <= rx_wait_d;
      if (ovr_set)      ovr_q <= 1'b1;
      else if (err_clr) ovr_q <= 1'b0;
      if (ferr_set)     ferr_q <= 1'b1;
      else if (err_clr) ferr_q <= 1'b0;
    end
  end

  assign rx_overrun   = ovr_q;
  assign rx_frame_err = ferr_q;

endmodule

// File: tb/tb_ikbd_serial_link.sv
// Self-checking bench for ikbd_serial_link: 8N1 line encode/decode against a queue-based model.
module tb_ikbd_serial_link;

  localparam int BITC = 256;

  logic       CLKx2 = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       rx_ready = 1'b0;
  logic       ser_rxd = 1'b1;
  logic       err_clr = 1'b0;
  logic       tx_ready, rx_valid, ser_txd, rx_overrun, rx_frame_err, tx_busy;
  logic [7:0] rx_data;

  ikbd_serial_link dut (
    .CLKx2(CLKx2), .RST_N(RST_N), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .ser_txd(ser_txd),
    .ser_rxd(ser_rxd), .err_clr(err_clr), .rx_overrun(rx_overrun),
    .rx_frame_err(rx_frame_err), .tx_busy(tx_busy)
  );

  always #5 CLKx2 = ~CLKx2;

  int cyc = 0;
  always @(posedge CLKx2) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_push;
    logic       exp_ferr;
  } rx_vec_t;

  rx_vec_t    vecs[5];
  logic [7:0] got[5];
  int         tt[5];
  bit         okv[5];
  logic [7:0] rq[$];
  logic [7:0] tq[$];
  logic [7:0] ra[5];
  logic [7:0] b8;
  int         lat;

  task automatic tick();
    @(posedge CLKx2);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb);
    ser_rxd = 1'b0;
    repeat (BITC) tick();
    for (int i = 0; i < 8; i++) begin
      ser_rxd = b[i];
      repeat (BITC) tick();
    end
    ser_rxd = stopb;
    repeat (BITC) tick();
    ser_rxd = 1'b1;
  endtask

  task automatic pop_rx(output logic [7:0] b);
    b = rx_data;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  // Mid-bit UART sampler on ser_txd; t0 is the cycle the start bit was first seen low.
  task automatic decode_tx(output logic [7:0] b, output int t0, output bit ok);
    int w;
    w = 0; ok = 1'b1; b = 8'h00; t0 = -1;
    while (ser_txd !== 1'b0 && w < 6000) begin
      tick();
      w++;
    end
    if (w >= 6000) begin
      ok = 1'b0;
    end else begin
      t0 = cyc;
      repeat (BITC/2) tick();
      if (ser_txd !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (BITC) tick();
        b[i] = ser_txd;
      end
      repeat (BITC) tick();
      if (ser_txd !== 1'b1) ok = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h3C, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'hFF, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h12, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h55, 1'b0, 1'b0, 1'b1};
    lat = 0;

    repeat (3) tick();
    RST_N = 1'b1;
    tick();

    // Reset in the middle of a transmitted frame
    tx_data = 8'h00; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (300) tick();
    check("mid-frame line low before reset", ser_txd, 1'b0);
    RST_N = 1'b0;
    #1;
    check("reset ser_txd async", ser_txd, 1'b1);
    tick(); tick();
    check("reset tx_ready", tx_ready, 1'b1);
    check("reset rx_valid", rx_valid, 1'b0);
    check("reset rx_data", rx_data, 8'h00);
    check("reset rx_overrun", rx_overrun, 1'b0);
    check("reset rx_frame_err", rx_frame_err, 1'b0);
    check("reset tx_busy", tx_busy, 1'b0);
    RST_N = 1'b1;
    repeat (4) tick();
    check("post-reset ser_txd", ser_txd, 1'b1);
    check("post-reset tx_busy", tx_busy, 1'b0);

    // Single byte 0xA5, cycle-exact line check
    begin
      logic [9:0] fr;
      int errs;
      fr = {1'b1, 8'hA5, 1'b0};
      tx_data = 8'hA5; tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      tick();
      check("tx first-edge latency idle", ser_txd, 1'b1);
      for (int b = 0; b < 10; b++) begin
        errs = 0;
        for (int k = 0; k < BITC; k++) begin
          tick();
          if (ser_txd !== fr[b]) errs++;
          if (b == 9 && k == BITC/2) check("tx_busy during stop", tx_busy, 1'b1);
        end
        check($sformatf("A5 bit%0d mismatching cycles", b), errs, 0);
      end
      tick();
      check("tx_busy after stop", tx_busy, 1'b0);
      check("line idle after stop", ser_txd, 1'b1);
    end

    // Five bytes back to back
    fork
      begin
        bit acc;
        int w;
        for (int i = 1; i <= 5; i++) begin
          tx_data = 8'(i); tx_valid = 1'b1; acc = 1'b0; w = 0;
          while (!acc && w < 10000) begin
            acc = tx_ready;
            tick();
            w++;
          end
        end
        tx_valid = 1'b0;
        check("tx_ready with 4 queued", tx_ready, 1'b0);
      end
      begin
        for (int k = 0; k < 5; k++) decode_tx(got[k], tt[k], okv[k]);
      end
    join
    for (int k = 0; k < 5; k++) begin
      check($sformatf("b2b frame%0d ok", k), okv[k], 1'b1);
      check($sformatf("b2b frame%0d data", k), got[k], 8'(k + 1));
      if (k > 0) check($sformatf("b2b frame%0d spacing", k), tt[k] - tt[k-1], 10 * BITC);
    end
    repeat (200) tick();
    check("tx_busy after b2b", tx_busy, 1'b0);

    // Random bytes with random valid gaps against an in-order queue model
    tq.delete();
    fork
      begin
        int gap;
        for (int i = 0; i < 4; i++) begin
          tx_data = 8'($urandom);
          tx_valid = 1'b1;
          while (!tx_ready) tick();
          tq.push_back(tx_data);
          tick();
          tx_valid = 1'b0;
          gap = $urandom_range(0, 2);
          repeat (gap) tick();
        end
      end
      begin
        for (int k = 0; k < 4; k++) decode_tx(got[k], tt[k], okv[k]);
      end
    join
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rand tx frame%0d ok", k), okv[k], 1'b1);
      check($sformatf("rand tx frame%0d data", k), got[k], (tq.size() > k) ? tq[k] : 8'hxx);
    end

    // Table-driven RX frames
    for (int i = 0; i < 5; i++) begin
      clear_errs();
      if (i == 0) begin
        fork
          send_rx(vecs[i].data, vecs[i].stop);
          begin
            while (rx_valid !== 1'b1 && lat < 4000) begin
              tick();
              lat++;
            end
          end
        join
        check("rx push latency in stop bit", (lat > 9 * BITC && lat < 10 * BITC) ? 1 : 0, 1);
      end else begin
        send_rx(vecs[i].data, vecs[i].stop);
      end
      repeat (20) tick();
      check($sformatf("rxvec%0d valid", i), rx_valid, vecs[i].exp_push);
      check($sformatf("rxvec%0d frame_err", i), rx_frame_err, vecs[i].exp_ferr);
      check($sformatf("rxvec%0d overrun", i), rx_overrun, 1'b0);
      if (vecs[i].exp_push) begin
        pop_rx(b8);
        check($sformatf("rxvec%0d data", i), b8, vecs[i].data);
      end
    end

    // Short glitch on the idle line
    clear_errs();
    ser_rxd = 1'b0;
    repeat (100) tick();
    ser_rxd = 1'b1;
    repeat (400) tick();
    check("glitch no byte", rx_valid, 1'b0);
    check("glitch no frame_err", rx_frame_err, 1'b0);
    check("glitch no overrun", rx_overrun, 1'b0);

    // Five frames with no pops: capacity-4 model predicts overrun on the fifth
    begin
      bit exp_ovr;
      rq.delete();
      exp_ovr = 1'b0;
      for (int i = 0; i < 5; i++) begin
        ra[i] = 8'($urandom);
        send_rx(ra[i], 1'b1);
        if (rq.size() < 4) rq.push_back(ra[i]);
        else exp_ovr = 1'b1;
      end
      repeat (20) tick();
      check("overrun set", rx_overrun, exp_ovr);
      clear_errs();
      check("overrun cleared", rx_overrun, 1'b0);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("ovr pop%0d valid", i), rx_valid, 1'b1);
        pop_rx(b8);
        check($sformatf("ovr pop%0d data", i), b8, rq.pop_front());
      end
      check("ovr drained", rx_valid, 1'b0);
    end

    // Pop coinciding with the fifth push on a full FIFO: no overrun, slot reused
    for (int i = 0; i < 4; i++) begin
      ra[i] = 8'($urandom);
      send_rx(ra[i], 1'b1);
    end
    ra[4] = 8'($urandom);
    fork
      send_rx(ra[4], 1'b1);
      begin
        repeat (lat - 1) tick();
        check("concurrent head", rx_data, ra[0]);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
      end
    join
    repeat (20) tick();
    check("concurrent no overrun", rx_overrun, 1'b0);
    for (int i = 1; i < 5; i++) begin
      pop_rx(b8);
      check($sformatf("concurrent pop%0d data", i), b8, ra[i]);
    end
    check("concurrent drained", rx_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
